inst_rom: RTL
=============

# inst_rom

Instruction memory that answers the fetch requests issued by the PC register: it samples the `pc`/`ce` pair each cycle and returns the addressed 32-bit instruction one cycle later. A byte-serial loader port fills the array before or between runs, so the same block serves as boot ROM and as a reloadable program store. It sits between the PC register and the IF/ID pipeline register.

## Interface
- `ADDR_W`, default 10: word-index width; the array holds 2^ADDR_W 32-bit words, covering byte addresses 0 .. 4·2^ADDR_W − 1.
- `clk` in 1: sole clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-low. It clears all registers immediately and does not clear the array contents.
- `ce` in 1: fetch enable from the PC register; 1 means request.
- `addr` in 32: fetch byte address (the PC).
- `inst` out 32: fetched instruction; 32'h00000000 when no valid fetch.
- `inst_valid` out 1: `inst` holds a real array word.
- `fetch_err` out 1: the previous fetch was misaligned or out of range.
- `ld_en` in 1: level; 1 selects load mode and suspends fetch.
- `ld_byte` in 8: loader data byte.
- `ld_valid` in 1: `ld_byte` is offered this cycle.
- `ld_ready` out 1: the block accepts a byte this cycle.
- `ld_full` out 1: the array has been completely written during this load session.
- `ld_words` out ADDR_W+1: count of words committed in the current load session.

## Operation
- **State machine:** FETCH, LOAD, WRITE. Reset enters FETCH.
- **FETCH → LOAD:** when `ld_en` = 1. On entry the byte counter is cleared to 0, `ld_words` to 0 and `ld_full` to 0.
- **LOAD:**
  - `ld_ready` = !`ld_full`.
  - A byte transfers when `ld_valid` and `ld_ready` are both 1.
  - Bytes are packed big-endian: the first byte goes to [31:24], the fourth to [7:0].
  - Acceptance of the fourth byte moves to WRITE.
- **WRITE:** lasts one cycle.
  - `ld_ready` = 0.
  - The assembled word is written at index `ld_words`, then `ld_words` increments.
  - When `ld_words` reaches 2^ADDR_W, `ld_full` sets.
  - Next state is LOAD.
- **Leaving LOAD:**
  - If `ld_en` = 0 while in LOAD, the block returns to FETCH next cycle. Any partial word (1–3 bytes) is discarded and the array is unchanged.
  - If `ld_en` = 0 while in WRITE, the write still completes, then the block goes to FETCH.
- **ld_full:** while set, the block stays in LOAD with `ld_ready` = 0 and ignores bytes until `ld_en` falls. `ld_words` saturates at 2^ADDR_W and never wraps.
- **Fetch, in FETCH only:** each cycle `ce`/`addr` are sampled and the result is registered.
  - ce = 0: `inst` = 0, `inst_valid` = 0, `fetch_err` = 0.
  - ce = 1 with `addr[1:0]` ≠ 0, or `addr[31:ADDR_W+2]` ≠ 0: `inst` = 0, `inst_valid` = 0, `fetch_err` = 1.
  - Otherwise: `inst` = array[`addr[ADDR_W+1:2]`], `inst_valid` = 1, `fetch_err` = 0.
- **Fetch in LOAD/WRITE:** fetches are ignored. `inst` = 0 and `inst_valid` = `fetch_err` = 0 in every cycle whose sampling edge occurs in LOAD or WRITE.
- **Array power-up:** the array is uninitialised; simulation may preload it via `$readmemh` under a compile-time define.

## Timing
- **Reset values:** `inst` = 0, `inst_valid` = 0, `fetch_err` = 0, `ld_ready` = 0, `ld_full` = 0, `ld_words` = 0, state = FETCH.
- **Fetch latency:** 1 cycle. The request sampled at edge N produces `inst` that is valid after edge N and holds until edge N+1. Back-to-back fetches sustain one instruction per cycle.
- **Read/write ordering:** a write committed at edge N is visible to a fetch sampled at edge N+1 or later. The first fetch after leaving load mode is therefore sampled at least one edge after the final WRITE edge.
- **Load throughput:** at most 4 bytes per 5 cycles (4 accept cycles plus 1 WRITE).
- **Mid-operation reset:** asserting `rst` low mid-load drops the partial word and the session. Words already committed stay in the array.
- **Simultaneous `ld_en` rise and `ce` = 1:** load has priority. That fetch is ignored and the outputs go to 0.

## Test plan
- **Reset:** hold `rst` low for 3 cycles with `ce` = 1 → all outputs 0. Release, then fetch `addr` = 0 → one cycle later `inst_valid` = 1.
- **Load then fetch:**
  - Stimulus: with `ld_en` = 1, stream bytes 12 34 56 78 AB CD EF 01, then drop `ld_en`. Fetch addr 0, then addr 4.
  - Response: `ld_words` = 2; `inst` = 32'h12345678, then 32'h ABCDEF01, each 1 cycle after its request; `ld_ready` low exactly on the 2 WRITE cycles.
- **Abort:** send 2 bytes (AA, BB), drop `ld_en`, fetch addr 8 → array word 2 unchanged, `ld_words` was 0.
- **Errors:** `ce` = 1 with `addr` = 32'h00000002 → `fetch_err` = 1, `inst` = 0. With ADDR_W = 10, `addr` = 32'h00001000 → `fetch_err` = 1. With `ce` = 0 → all fetch outputs 0.
- **Full:** with ADDR_W = 2, stream 20 bytes → after 16 bytes `ld_full` = 1 and `ld_words` = 4; the remaining 4 bytes are never accepted (`ld_ready` = 0); words 0–3 read back correctly.
- **Streaming fetch:** `ce` = 1 with addr 0, 4, 8, 12 on consecutive cycles → 4 consecutive `inst_valid` cycles in order, no bubbles.

Source files
------------

// File: rtl/inst_rom_if.sv
// Fetch and byte-loader bus of the instruction memory.
// master: PC register / loader side; slave: inst_rom.
interface inst_rom_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              ce;
    logic [31:0]       addr;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              fetch_err;
    logic              ld_en;
    logic [7:0]        ld_byte;
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_full;
    logic [ADDR_W:0]   ld_words;

    modport master (
        output ce, addr, ld_en, ld_byte, ld_valid,
        input  inst, inst_valid, fetch_err, ld_ready, ld_full, ld_words
    );

    modport slave (
        input  ce, addr, ld_en, ld_byte, ld_valid,
        output inst, inst_valid, fetch_err, ld_ready, ld_full, ld_words
    );
endinterface

// File: rtl/inst_rom.sv
// Instruction memory with one-cycle registered fetch and a byte-serial,
// big-endian loader that refills the array from word 0 each load session.
module inst_rom #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic      clk,
    input  logic      rst,
    inst_rom_if.slave bus
);
    localparam int unsigned     DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]       mem [DEPTH];
    logic [1:0]        byte_cnt;
    logic [31:0]       word_buf;
    logic [ADDR_W:0]   words_q;
    logic              full_q;
    logic [31:0]       inst_q;
    logic              valid_q;
    logic              err_q;

    logic              ready;
    logic              accept;
    logic              last_byte;
    logic              fetch_ok;
    logic              addr_err;
    logic [ADDR_W-1:0] fetch_idx;

    always_comb begin
        ready     = (state_q == LOAD) && !full_q;
        // Bytes offered in the cycle ld_en drops would be discarded anyway.
        accept    = ready && bus.ld_valid && bus.ld_en;
        last_byte = accept && (byte_cnt == 2'd3);
        fetch_ok  = (state_q == FETCH) && !bus.ld_en && bus.ce;
        addr_err  = (bus.addr[1:0] != 2'b00) || ((bus.addr >> (ADDR_W + 2)) != 32'd0);
        fetch_idx = bus.addr[ADDR_W+1:2];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (bus.ld_en) state_d = LOAD;
            end
            LOAD: begin
                if (!bus.ld_en)     state_d = FETCH;
                else if (last_byte) state_d = WRITE;
            end
            WRITE: begin
                state_d = bus.ld_en ? LOAD : FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FETCH;
            byte_cnt <= '0;
            word_buf <= '0;
            words_q  <= '0;
            full_q   <= 1'b0;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            case (state_q)
                FETCH: begin
                    if (bus.ld_en) begin
                        byte_cnt <= '0;
                        words_q  <= '0;
                        full_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        word_buf <= {word_buf[23:0], bus.ld_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    if (!full_q) begin
                        words_q <= words_q + ONE;
                        full_q  <= (words_q + ONE) == FULL_CNT;
                    end
                end
                default: ;
            endcase

            if (fetch_ok && addr_err) begin
                inst_q  <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b1;
            end else if (fetch_ok) begin
                inst_q  <= mem[fetch_idx];
                valid_q <= 1'b1;
                err_q   <= 1'b0;
            end else begin
                inst_q  <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end
        end
    end

    // Array has no reset so committed words survive a mid-load reset.
    always_ff @(posedge clk) begin
        if (state_q == WRITE && !full_q) begin
            mem[words_q[ADDR_W-1:0]] <= word_buf;
        end
    end

    assign bus.inst       = inst_q;
    assign bus.inst_valid = valid_q;
    assign bus.fetch_err  = err_q;
    assign bus.ld_ready   = ready;
    assign bus.ld_full    = full_q;
    assign bus.ld_words   = words_q;
endmodule
